// File: rtl/axil_wb_bridge.sv
// AXI4-Lite slave to pipelined Wishbone B4 master bridge, one transaction in flight.
// Adds window decode (DECERR), stall handling, err->SLVERR mapping, a watchdog and R/W round-robin.
module axil_wb_bridge #(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    WB_ADDR_WIDTH  = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter logic [ADDR_WIDTH-1:0] ADDR_SPAN      = 'h100,
  parameter int                    TIMEOUT_CYCLES = 255
) (
  input  logic                     i_clk_100,
  input  logic                     i_rst_100_n,
  input  logic                     i_axil_AWVALID,
  output logic                     o_axil_AWREADY,
  input  logic [ADDR_WIDTH-1:0]    i_axil_AWADDR,
  input  logic [2:0]               i_axil_AWPROT,
  input  logic                     i_axil_WVALID,
  output logic                     o_axil_WREADY,
  input  logic [DATA_WIDTH-1:0]    i_axil_WDATA,
  input  logic [DATA_WIDTH/8-1:0]  i_axil_WSTRB,
  output logic                     o_axil_BVALID,
  input  logic                     i_axil_BREADY,
  output logic [1:0]               o_axil_BRESP,
  input  logic                     i_axil_ARVALID,
  output logic                     o_axil_ARREADY,
  input  logic [ADDR_WIDTH-1:0]    i_axil_ARADDR,
  input  logic [2:0]               i_axil_ARPROT,
  output logic                     o_axil_RVALID,
  input  logic                     i_axil_RREADY,
  output logic [DATA_WIDTH-1:0]    o_axil_RDATA,
  output logic [1:0]               o_axil_RRESP,
  output logic                     o_wb_cyc,
  output logic                     o_wb_stb,
  output logic                     o_wb_we,
  output logic [WB_ADDR_WIDTH-1:0] o_wb_addr,
  output logic [DATA_WIDTH-1:0]    o_wb_data,
  output logic [DATA_WIDTH/8-1:0]  o_wb_sel,
  input  logic                     i_wb_stall,
  input  logic                     i_wb_ack,
  input  logic                     i_wb_err,
  input  logic [DATA_WIDTH-1:0]    i_wb_data
);

  // state   | meaning
  // IDLE    | waiting for a write (AW+W) or read (AR) candidate; grants one
  // WB_REQ  | cyc+stb asserted, waiting for the slave to stop stalling
  // WB_WAIT | request accepted, cyc held until ack/err or watchdog expiry
  // RESP    | B or R channel valid, waiting for the master's READY
  typedef enum logic [1:0] {IDLE, WB_REQ, WB_WAIT, RESP} state_t;

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int WDW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [ADDR_WIDTH:0] WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [ADDR_WIDTH:0] WIN_HI = {1'b0, BASE_ADDR} + {1'b0, ADDR_SPAN};

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  state_t                  state;
  logic                    prefer_wr;
  logic [WDW-1:0]          wdog;
  logic [1:0]              resp;
  logic                    wr_cand, rd_cand, grant_wr, grant_rd;
  logic [ADDR_WIDTH-1:0]   req_addr, req_off;
  logic                    in_range, wb_term, wd_fire;
  logic                    unused_ok;

  assign wr_cand  = i_axil_AWVALID && i_axil_WVALID;
  assign rd_cand  = i_axil_ARVALID;
  assign grant_wr = i_rst_100_n && (state == IDLE) && wr_cand && (!rd_cand || prefer_wr);
  assign grant_rd = i_rst_100_n && (state == IDLE) && rd_cand && (!wr_cand || !prefer_wr);

  assign o_axil_AWREADY = grant_wr;
  assign o_axil_WREADY  = grant_wr;
  assign o_axil_ARREADY = grant_rd;

  // Widen by one bit so a window ending at the top of the address space still decodes.
  assign req_addr = grant_wr ? i_axil_AWADDR : i_axil_ARADDR;
  assign in_range = ({1'b0, req_addr} >= WIN_LO) && ({1'b0, req_addr} < WIN_HI);
  assign req_off  = req_addr - BASE_ADDR;

  assign wb_term = (((state == WB_REQ) && !i_wb_stall) || (state == WB_WAIT))
                   && (i_wb_ack || i_wb_err);
  assign wd_fire = (TIMEOUT_CYCLES != 0) && ((state == WB_REQ) || (state == WB_WAIT))
                   && !wb_term && (wdog == WD_LAST);

  assign o_axil_BRESP = resp;
  assign o_axil_RRESP = resp;
  assign unused_ok    = ^{i_axil_AWPROT, i_axil_ARPROT, req_off};

  always_ff @(posedge i_clk_100) begin
    if (!i_rst_100_n) begin
      state         <= IDLE;
      prefer_wr     <= 1'b1;
      wdog          <= '0;
      resp          <= RESP_OKAY;
      o_axil_BVALID <= 1'b0;
      o_axil_RVALID <= 1'b0;
      o_axil_RDATA  <= '0;
      o_wb_cyc      <= 1'b0;
      o_wb_stb      <= 1'b0;
      o_wb_we       <= 1'b0;
      o_wb_addr     <= '0;
      o_wb_data     <= '0;
      o_wb_sel      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_wr || grant_rd) begin
            prefer_wr <= grant_rd;
            o_wb_we   <= grant_wr;
            o_wb_addr <= req_off[LSB +: WB_ADDR_WIDTH];
            o_wb_data <= grant_wr ? i_axil_WDATA : '0;
            o_wb_sel  <= grant_wr ? i_axil_WSTRB : '1;
            if (!in_range) begin
              resp          <= RESP_DECERR;
              o_axil_RDATA  <= '0;
              o_axil_BVALID <= grant_wr;
              o_axil_RVALID <= grant_rd;
              state         <= RESP;
            end else if (grant_wr && (i_axil_WSTRB == '0)) begin
              resp          <= RESP_OKAY;
              o_axil_BVALID <= 1'b1;
              state         <= RESP;
            end else begin
              o_wb_cyc <= 1'b1;
              o_wb_stb <= 1'b1;
              wdog     <= '0;
              state    <= WB_REQ;
            end
          end
        end
        WB_REQ, WB_WAIT: begin
          wdog <= wdog + WDW'(1);
          if (wb_term || wd_fire) begin
            // err beats a simultaneous ack; an expired watchdog reads back zero.
            o_wb_cyc      <= 1'b0;
            o_wb_stb      <= 1'b0;
            resp          <= (wd_fire || i_wb_err) ? RESP_SLVERR : RESP_OKAY;
            if (!o_wb_we)
              o_axil_RDATA <= (wb_term && !i_wb_err) ? i_wb_data : '0;
            o_axil_BVALID <= o_wb_we;
            o_axil_RVALID <= !o_wb_we;
            state         <= RESP;
          end else if ((state == WB_REQ) && !i_wb_stall) begin
            o_wb_stb <= 1'b0;
            state    <= WB_WAIT;
          end
        end
        RESP: begin
          if ((o_axil_BVALID && i_axil_BREADY) || (o_axil_RVALID && i_axil_RREADY)) begin
            o_axil_BVALID <= 1'b0;
            o_axil_RVALID <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
